// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer/deserializer state encoding and default baud divisor.
// Used by uart_tx_drain today and by the receive-side fill block later.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // 50 MHz system clock / 115200 baud
    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// clear holds the count at zero so a new frame always starts on a full bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || cnt_q == LAST) cnt_d = '0;
        else                        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = ~clear & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains an external normal-mode TX FIFO one byte at a time and serializes it as 8N1, LSB first.
// txd is a flop so the line never glitches between states.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] fifo_q,
    output logic       rdreq,
    output logic       txd,
    output logic       busy
);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic        txd_q;
    logic        baud_clr;
    logic        tick;

    // Counter held at zero until START so the start bit gets a full period.
    assign baud_clr = (state_q == IDLE) || (state_q == FETCH);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (!empty) state_q <= FETCH;
                end
                // fifo_q is valid now, one cycle after the IDLE read request
                FETCH: begin
                    shift_q <= fifo_q;
                    bit_q   <= '0;
                    txd_q   <= 1'b0;
                    state_q <= START;
                end
                START: begin
                    if (tick) begin
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) state_q <= IDLE;
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst so no byte is popped while the block is held in reset.
    assign rdreq = (state_q == IDLE) & ~empty & ~rst;
    assign busy  = (state_q != IDLE);
    assign txd   = txd_q;

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port empty  input  1  TX FIFO empty flag.
REQ-005 SHALL have port fifo_q  input  8  TX FIFO read data, valid the cycle after rdreq (normal, non-show-ahead mode).
REQ-006 SHALL have port rdreq  output  1  FIFO read request, one cycle per byte.
REQ-007 SHALL have port txd  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL use states IDLE, FETCH, START, DATA, STOP.
REQ-010 SHALL drive rdreq combinationally as (state==IDLE) & ~empty; it is never asserted in any other state.
REQ-011 IDLE: when ~empty, SHALL move to FETCH on the next edge; otherwise SHALL stay in IDLE with txd=1.
REQ-012 FETCH: SHALL latch fifo_q into an 8-bit shift register, clear the bit counter and baud counter, and move to START; FETCH lasts exactly one cycle.
REQ-013 START: SHALL drive txd=0 for exactly CLKS_PER_BIT cycles, then move to DATA.
REQ-014 DATA: SHALL drive txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit, for 8 bits (LSB first), then move to STOP.
REQ-015 STOP: SHALL drive txd=1 for exactly CLKS_PER_BIT cycles, then move to IDLE.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; the bit-end tick is asserted when count==CLKS_PER_BIT-1.
REQ-017 Bit counter SHALL be 3 bits; DATA SHALL exit on the tick where bit count==7.
REQ-018 txd SHALL be a registered output and glitch-free.
REQ-019 Frame length from the FETCH edge to the return to IDLE SHALL be 10*CLKS_PER_BIT cycles; back-to-back bytes SHALL have a 2-cycle inter-frame gap (IDLE plus FETCH) with txd=1.
REQ-020 empty rising while in START/DATA/STOP SHALL NOT affect the current frame.
REQ-021 A FIFO write during IDLE with empty low SHALL be picked up on the same cycle; there is no extra latency.
REQ-022 CLKS_PER_BIT values below 2 are unsupported; the counter width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-023 On rst assertion, the block SHALL immediately (asynchronously) enter IDLE with txd=1, busy=0, rdreq=0, all counters=0 and shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame; the byte is lost, with no re-read and no partial-frame recovery.
REQ-025 After rst deasserts, the first rdreq SHALL occur in the first cycle in which empty=0.

Structure
REQ-026 State encodings and the default CLKS_PER_BIT SHALL live in the shared package uart_pkg, which the future uart_rx_fill also uses.
REQ-027 The baud counter SHALL be a sub-module uart_baud_gen with inputs clk, rst and clear, and output tick.
REQ-028 The FIFO itself SHALL be external; this block SHALL contain only the reader and serializer.

Verification (bench CLKS_PER_BIT=4)
REQ-029 FIFO holds 0x55, empty drops -> exactly one rdreq pulse; txd reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy is high for 41 cycles (FETCH plus 40).
REQ-030 FIFO holds 0xA3 then 0x0F -> two frames with LSB-first data 11000101 and 11110000; 2-cycle txd-high gap between them; exactly two rdreq pulses.
REQ-031 empty held high for 200 cycles -> rdreq=0, txd=1 and busy=0 throughout.
REQ-032 rst pulsed during data bit 3 of 0xFF -> txd=1 in the same cycle; state IDLE; the next frame after reset carries the next FIFO byte, not 0xFF.
REQ-033 Bytes 0x00 and 0xFF sent -> txd low for 36 consecutive cycles (start plus 8 data bits); for 0xFF, txd low for only the 4 start cycles; stop bit present in both cases.
REQ-034 A scoreboard receiver SHALL sample each bit mid-period, compare every frame with the FIFO write order, and flag any framing error.
